// File: rtl/pbvi_decision.sv
`default_nettype none
// ============================================================================
//  Module      : pbvi_decision
//  Description : Picks the alpha vector with the largest dot product against
//                the latched two-state belief; scans one entry per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pbvi_decision #(
    parameter int NUM_ALPHA = 8,
    parameter int IDX_W     = $clog2(NUM_ALPHA + 1)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic [0:1][15:0]                    belief,
    input  logic [0:NUM_ALPHA-1][0:1][15:0]     alpha_value,
    input  logic [0:NUM_ALPHA-1][1:0]           alpha_action,
    input  logic [IDX_W-1:0]                    alpha_count,
    output logic [1:0]                          action,
    output logic [32:0]                         best_value,
    output logic                                action_valid,
    output logic                                busy
);

    localparam int c_SEL_W = (NUM_ALPHA > 1) ? $clog2(NUM_ALPHA) : 1;
    localparam logic [IDX_W-1:0] c_MAX_COUNT = IDX_W'(NUM_ALPHA);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_count;
    logic [15:0]      r_b0;
    logic [15:0]      r_b1;
    logic [32:0]      r_max;
    logic [1:0]       r_max_act;

    logic [IDX_W-1:0]   w_count;
    logic [c_SEL_W-1:0] w_sel;
    logic [15:0]        w_a0;
    logic [15:0]        w_a1;
    logic [31:0]        w_p0;
    logic [31:0]        w_p1;
    logic [32:0]        w_v;
    logic               w_take;
    logic [32:0]        w_run_max;
    logic [1:0]         w_run_act;
    logic               w_last;

    assign w_count = (alpha_count > c_MAX_COUNT) ? c_MAX_COUNT : alpha_count;

    // idx never reaches NUM_ALPHA while scanning, so the narrow select is safe
    assign w_sel = r_idx[c_SEL_W-1:0];
    assign w_a0  = alpha_value[w_sel][0];
    assign w_a1  = alpha_value[w_sel][1];
    assign w_p0  = {16'd0, w_a0} * {16'd0, r_b0};
    assign w_p1  = {16'd0, w_a1} * {16'd0, r_b1};
    assign w_v   = {1'b0, w_p0} + {1'b0, w_p1};

    // strict compare keeps the lowest index on ties
    assign w_take    = (r_idx == '0) || (w_v > r_max);
    assign w_run_max = w_take ? w_v : r_max;
    assign w_run_act = w_take ? alpha_action[w_sel] : r_max_act;
    assign w_last    = (r_idx == (r_count - 1'b1));

    assign busy = (r_state != c_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_idx        <= '0;
            r_count      <= '0;
            r_b0         <= '0;
            r_b1         <= '0;
            r_max        <= '0;
            r_max_act    <= '0;
            action       <= '0;
            best_value   <= '0;
            action_valid <= 1'b0;
        end else begin
            action_valid <= 1'b0;
            if (en) begin
                // a new request always wins, aborting any scan in flight
                r_b0      <= belief[0];
                r_b1      <= belief[1];
                r_count   <= w_count;
                r_idx     <= '0;
                r_max     <= '0;
                r_max_act <= '0;
                if (w_count == '0) begin
                    action       <= '0;
                    best_value   <= '0;
                    action_valid <= 1'b1;
                    r_state      <= c_DONE;
                end else begin
                    r_state <= c_SCAN;
                end
            end else begin
                case (r_state)
                    c_IDLE: r_state <= c_IDLE;
                    c_SCAN: begin
                        r_max     <= w_run_max;
                        r_max_act <= w_run_act;
                        if (w_last) begin
                            action       <= w_run_act;
                            best_value   <= w_run_max;
                            action_valid <= 1'b1;
                            r_state      <= c_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    c_DONE:  r_state <= c_IDLE;
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pbvi_decision.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pbvi_decision
//  Description : Directed self-checking bench for pbvi_decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pbvi_decision;

    localparam int NUM_ALPHA = 8;
    localparam int IDX_W     = $clog2(NUM_ALPHA + 1);

    logic                            clk;
    logic                            rst_n;
    logic                            en;
    logic [0:1][15:0]                belief;
    logic [0:NUM_ALPHA-1][0:1][15:0] alpha_value;
    logic [0:NUM_ALPHA-1][1:0]       alpha_action;
    logic [IDX_W-1:0]                alpha_count;
    logic [1:0]                      action;
    logic [32:0]                     best_value;
    logic                            action_valid;
    logic                            busy;

    int compared   = 0;
    int mismatched = 0;

    pbvi_decision #(.NUM_ALPHA(NUM_ALPHA)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .belief       (belief),
        .alpha_value  (alpha_value),
        .alpha_action (alpha_action),
        .alpha_count  (alpha_count),
        .action       (action),
        .best_value   (best_value),
        .action_valid (action_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NUM_ALPHA; i++) begin
            alpha_value[i][0] = '0;
            alpha_value[i][1] = '0;
            alpha_action[i]   = '0;
        end
    endtask

    // Called #1 after a clock edge (cycle 0); returns #1 after the next edge (cycle 1).
    task automatic pulse_en(input logic [15:0] b0, input logic [15:0] b1, input logic [IDX_W-1:0] cnt);
        belief[0]   = b0;
        belief[1]   = b1;
        alpha_count = cnt;
        en          = 1'b1;
        step();
        en          = 1'b0;
    endtask

    // Currently at cycle k_first; checks cycles k_first..k_last, valid only at k_valid.
    task automatic watch(input string tag, input int k_first, input int k_last, input int k_valid,
                         input logic [1:0] exp_act, input logic [32:0] exp_val);
        for (int k = k_first; k <= k_last; k++) begin
            if (k != k_first) step();
            chk({tag, "_valid"}, 64'(action_valid), 64'(k == k_valid));
            if (k == k_valid) begin
                chk({tag, "_action"}, 64'(action), 64'(exp_act));
                chk({tag, "_value"}, 64'(best_value), 64'(exp_val));
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        belief      = '0;
        alpha_count = '0;
        clear_table();
        step();
        step();
        chk("reset_action", 64'(action), 64'd0);
        chk("reset_value", 64'(best_value), 64'd0);
        chk("reset_valid", 64'(action_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic select: 0.5/0.5 belief, entry 2 wins with 400*32768
        clear_table();
        alpha_value[0][0] = 16'd100; alpha_action[0] = 2'd0;
        alpha_value[1][1] = 16'd300; alpha_action[1] = 2'd1;
        alpha_value[2][0] = 16'd200; alpha_value[2][1] = 16'd200; alpha_action[2] = 2'd2;
        pulse_en(16'h8000, 16'h8000, 4'd3);
        chk("basic_busy", 64'(busy), 64'd1);
        watch("basic", 1, 6, 4, 2'd2, 33'd13107200);
        chk("hold_action", 64'(action), 64'd2);
        chk("hold_value", 64'(best_value), 64'd13107200);
        chk("basic_idle", 64'(busy), 64'd0);

        // Tie: both entries give 50*65535, lowest index wins
        clear_table();
        alpha_value[0][0] = 16'd50; alpha_value[0][1] = 16'd9; alpha_action[0] = 2'd3;
        alpha_value[1][0] = 16'd50; alpha_value[1][1] = 16'd1; alpha_action[1] = 2'd1;
        pulse_en(16'hFFFF, 16'h0000, 4'd2);
        watch("tie", 1, 5, 3, 2'd3, 33'd3276750);

        // Zero count: one-cycle DONE with zero result
        pulse_en(16'h1234, 16'h4321, 4'd0);
        chk("zero_busy1", 64'(busy), 64'd1);
        chk("zero_valid", 64'(action_valid), 64'd1);
        chk("zero_action", 64'(action), 64'd0);
        chk("zero_value", 64'(best_value), 64'd0);
        step();
        chk("zero_busy2", 64'(busy), 64'd0);
        chk("zero_valid2", 64'(action_valid), 64'd0);

        // Width boundary: full-scale sum needs all 33 bits
        clear_table();
        alpha_value[0][0] = 16'hFFFF; alpha_value[0][1] = 16'hFFFF; alpha_action[0] = 2'd1;
        pulse_en(16'hFFFF, 16'hFFFF, 4'd1);
        watch("width", 1, 4, 2, 2'd1, 33'h1FFFC0002);

        // Count clamp: 15 behaves as 8; entry i = (10*i, 0), last entry wins
        clear_table();
        for (int i = 0; i < NUM_ALPHA; i++) begin
            alpha_value[i][0] = 16'(10 * i);
            alpha_action[i]   = 2'(i);
        end
        pulse_en(16'd1, 16'd0, 4'd15);
        watch("clamp", 1, 11, 9, 2'd3, 33'd70);

        // Restart in cycle 3: only the second belief produces a result
        clear_table();
        alpha_value[1][0] = 16'd1000; alpha_action[1] = 2'd1;
        alpha_value[5][1] = 16'd1000; alpha_action[5] = 2'd2;
        pulse_en(16'hFFFF, 16'h0000, 4'd8);
        chk("restart_v1", 64'(action_valid), 64'd0);
        step();
        chk("restart_v2", 64'(action_valid), 64'd0);
        step();
        chk("restart_v3", 64'(action_valid), 64'd0);
        pulse_en(16'h0000, 16'h0100, 4'd8);
        watch("restart", 4, 14, 12, 2'd2, 33'd256000);

        // Asynchronous reset in cycle 2 of a count=8 scan
        pulse_en(16'hFFFF, 16'h0000, 4'd8);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_action", 64'(action), 64'd0);
        chk("rst_value", 64'(best_value), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(action_valid), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        watch("after_rst", 1, 10, 0, 2'd0, 33'd0);

        // Normal operation after reset
        pulse_en(16'hFFFF, 16'h0000, 4'd8);
        watch("post_rst", 1, 10, 9, 2'd1, 33'd65535000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
